// File: rtl/xor_serial_ctrl.sv
// Bit-serial A^B engine: streams operand bits LSB-first through an external
// 1-bit XOR cell and assembles the returned bits into y plus its parity.
module xor_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             xor_in1,
  output logic             xor_in2,
  input  logic             xor_out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             parity,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pacc_q, pacc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             parity_q, parity_d;

  // Handshake: start is taken only on an edge where ready=1 (IDLE); there is
  // no queuing, so a start seen in RUN or DONE is simply dropped.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    pacc_d   = pacc_q;
    y_d      = y_q;
    parity_d = parity_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          pacc_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          res_d  = {xor_out, res_q[WIDTH-1:1]};
          pacc_d = pacc_q ^ xor_out;
          a_d    = a_q >> 1;
          b_d    = b_q >> 1;
          // The counter holds at LAST instead of wrapping on the final capture.
          if (cnt_q == LAST) begin
            y_d      = res_d;
            parity_d = pacc_d;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      pacc_q   <= 1'b0;
      y_q      <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      pacc_q   <= pacc_d;
      y_q      <= y_d;
      parity_q <= parity_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign xor_in1   = busy & a_q[0];
  assign xor_in2   = busy & b_q[0];
  assign y         = y_q;
  assign parity    = parity_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_xor_serial_ctrl.sv
// Directed bench for xor_serial_ctrl (WIDTH=8) with a 1-bit XOR cell in the loop.
module tb_xor_serial_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             xor_in1;
  logic             xor_in2;
  logic             xor_out;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             parity;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  assign xor_out = xor_in1 ^ xor_in2;

  xor_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .xor_in1   (xor_in1),
    .xor_in2   (xor_in2),
    .xor_out   (xor_out),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .y         (y),
    .parity    (parity),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             p;
    logic             abort_with_start;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    chk("mutex_ready_busy_done", 32'($countones({busy, ready, done}) <= 1), 32'd1);
    if (!busy) chk("xor_in_zero_outside_run", {30'd0, xor_in1, xor_in2}, 32'd0);
  end

  // Called at a negedge; returns at the negedge after the IDLE cycle following DONE.
  task automatic run_op(input vec_t v);
    a = v.a; b = v.b; start = 1'b1; abort = v.abort_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("busy_after_start", busy, 1);
    repeat (WIDTH - 1) @(negedge clk);
    chk("no_done_before_last_capture", {busy, done}, 2'b10);
    @(negedge clk);
    chk("done_after_last_capture", done, 1);
    chk("y_result", y, v.y);
    chk("parity_result", parity, v.p);
    @(negedge clk);
    chk("ready_after_done", {ready, done}, 2'b10);
  endtask

  task automatic no_done_for(input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(name, seen, 0);
  endtask

  logic [WIDTH-1:0] y_hold;
  logic             p_hold;
  int               d1;
  int               d2;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h34, 8'h26, 1'b1, 1'b1};
    vecs[2] = '{8'h80, 8'h01, 8'h81, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h00, 8'h7F, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_outputs", {ready, busy, done, parity, xor_in1, xor_in2}, 6'b100000);
    chk("reset_y", y, 0);
    chk("reset_state", dbg_state, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release must accept start (vecs[0] begins here).
    foreach (vecs[i]) run_op(vecs[i]);

    // Back-to-back with start held high.
    d1 = -1; d2 = -1;
    a = 8'h01; b = 8'h00; start = 1'b1;
    @(negedge clk);
    a = 8'hFF;
    for (int n = 0; n < 30 && d2 < 0; n++) begin
      if (done && d1 < 0) begin
        d1 = n;
        chk("b2b_first_y", y, 8'h01);
        chk("b2b_first_parity", parity, 1);
      end else if (done) begin
        d2 = n;
        chk("b2b_second_y", y, 8'hFF);
        chk("b2b_second_parity", parity, 0);
      end
      if (n == 9) chk("b2b_idle_after_done", ready, 1);
      if (n == 10) chk("b2b_reaccepted", busy, 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_first_done_cycle", d1, 8);
    chk("b2b_done_spacing", d2 - d1, 10);
    @(negedge clk);

    // Restart ignored mid-RUN, then abort.
    y_hold = y; p_hold = parity;
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_ignored_in_run", busy, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ready_after_abort", {ready, busy, done}, 3'b100);
    no_done_for(12, "no_done_after_abort");
    chk("y_kept_after_abort", y, y_hold);
    chk("parity_kept_after_abort", parity, p_hold);

    // Abort in IDLE is a no-op.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ignored_in_idle", ready, 1);

    // Asynchronous reset mid-RUN.
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {ready, busy, done, parity, xor_in1, xor_in2}, 6'b100000);
    chk("async_reset_y", y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done_for(12, "no_done_after_reset");
    run_op('{8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_serial_ctrl.md
XOR_SERIAL_CTRL -- requirements
Module: xor_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only when ready=1.
REQ-005 abort  input  1  synchronous cancel of a running operation.
REQ-006 a  input  WIDTH  operand A; captured on accepted start.
REQ-007 b  input  WIDTH  operand B; captured on accepted start.
REQ-008 xor_in1  output  1  bit to the external 1-bit XOR cell, first input.
REQ-009 xor_in2  output  1  bit to the external 1-bit XOR cell, second input.
REQ-010 xor_out  input  1  result returned by the external XOR cell; combinational, same cycle.
REQ-011 ready  output  1  high in IDLE only.
REQ-012 busy  output  1  high in RUN only.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 y  output  WIDTH  registered result a^b; holds until the next completion.
REQ-015 parity  output  1  registered XOR-reduction of y; updated together with y.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE: when start=1 at a clock edge, the block SHALL capture a and b into shift registers, clear the bit counter, the result shifter and the running parity, and go to RUN.
REQ-018 RUN: xor_in1/xor_in2 SHALL equal bit 0 of the A/B shift registers; xor_in1/xor_in2 SHALL be 0 in every other state.
REQ-019 RUN, each edge: shift xor_out into the MSB of the result shifter (shift right); parity_acc ^= xor_out; shift the A/B registers right by 1; counter += 1.
REQ-020 The edge on which the counter equals WIDTH-1 SHALL be the last capture: load y from the final result shifter value and parity from the final parity_acc, then go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-022 Latency: with start accepted at edge E0, the captures occur at E1..E(WIDTH); done is high in the cycle after E(WIDTH); ready is high again after E(WIDTH+1).
REQ-023 The counter SHALL be ceil(log2(WIDTH)) bits and SHALL NOT wrap during an operation.
REQ-024 start SHALL be ignored in RUN and DONE, with no queuing; start in the DONE cycle SHALL NOT be accepted.
REQ-025 abort=1 in RUN SHALL return the FSM to IDLE on the next edge, with no done pulse and y/parity unchanged.
REQ-026 abort SHALL be ignored in IDLE and DONE.
REQ-027 start and abort both high in IDLE: start wins and abort is ignored.
REQ-028 Back-to-back operation: start held high SHALL be re-accepted in the first IDLE cycle after DONE, giving one operation every WIDTH+2 cycles.
REQ-029 y and parity SHALL change only at the RUN-to-DONE edge or on reset.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- y, parity, the counter, all shifters and parity_acc to 0;
- done=0, busy=0, ready=1, xor_in1=xor_in2=0.
REQ-031 Reset asserted mid-RUN SHALL discard the operation; no done pulse SHALL follow the release of reset.
REQ-032 After rst_n is released, the first edge SHALL be able to accept start.

Verification (WIDTH=8, bench connects a 1-bit XOR cell between xor_in1/xor_in2 and xor_out)
REQ-033 a=8'hA5, b=8'h3C, start pulse -> busy for 8 cycles, then done pulse; y=8'h99, parity=0; done exactly 9 cycles after the start edge.
REQ-034 a=8'h01, b=8'h00, then a=8'hFF, b=8'h00 with start held high -> first result y=8'h01, parity=1; second result y=8'hFF, parity=0; the two done pulses are 10 cycles apart.
REQ-035 Start a=8'hF0, b=8'h0F; pulse start again at RUN cycle 3; pulse abort at RUN cycle 5 -> no done pulse; y/parity keep their previous values; ready=1 one cycle after abort.
REQ-036 rst_n low mid-RUN for an asynchronous interval between edges -> outputs go to their reset values immediately, with no pending done; next operation a=8'h55, b=8'hAA -> y=8'hFF, parity=0.
REQ-037 The bench SHALL check on every cycle that xor_in1/xor_in2 are 0 outside RUN and that busy, ready and done are mutually exclusive.
